output_argmax_scorer: RTL

//  Sits directly downstream of the output layer. Consumes one NC-lane signed output vector
//  per sample and the matching class label. Finds the winning class by a sequential argmax

---
 rtl/output_argmax_scorer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/output_argmax_scorer.sv
// rtl/output_argmax_scorer.sv - sequential argmax over NC signed output lanes with accuracy counters
// Optional feature macro: OUTPUT_ARGMAX_SCORE_EN (adds oData_BM_Score, the winning lane value)
module output_argmax_scorer #(
    parameter int NP   = 7,
    parameter int NC   = 6,
    parameter int WF   = 5,
    parameter int WCNT = 16,
    localparam int WO  = $clog2(NP) + 1 + WF,
    localparam int WL  = (NC > 1) ? $clog2(NC) : 1
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iValid_AM_Output,
    output logic                 oReady_AM_Output,
    input  logic [NC*WO-1:0]     iData_AM_Output,
    input  logic                 iValid_AS_Label,
    output logic                 oReady_AS_Label,
    input  logic [WL-1:0]        iData_AS_Label,
    output logic                 oValid_BM_Class,
    input  logic                 iReady_BM_Class,
    output logic [WL-1:0]        oData_BM_Class,
`ifdef OUTPUT_ARGMAX_SCORE_EN
    output logic signed [WO-1:0] oData_BM_Score,
`endif
    output logic                 oHit,
    output logic [WCNT-1:0]      oCount_Total,
    output logic [WCNT-1:0]      oCount_Hit,
    input  logic                 iClear
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [WCNT-1:0] CNT_MAX  = '1;
    localparam logic [WL-1:0]   LAST_IDX = WL'(NC - 1);

    state_t state;
    state_t stateNext;

    // Captured sample: the whole vector and its label are frozen at the join.
    logic signed [WO-1:0] laneReg [NC];
    logic [WL-1:0]        labelReg;

    // Running argmax state and the lane pointer for the scan.
    logic signed [WO-1:0] bestVal;
    logic [WL-1:0]        bestIdx;
    logic [WL-1:0]        laneIdx;

    // Result of comparing the current lane against the running best.
    logic signed [WO-1:0] candVal;
    logic signed [WO-1:0] scanBestVal;
    logic [WL-1:0]        scanBestIdx;

    logic joinFire;
    logic retireFire;
    logic lastLane;

    assign lastLane = (laneIdx == LAST_IDX);

    // State register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and handshake outputs; ready is a join of both inputs and is
    // forced low while reset is asserted so nothing is accepted in reset.
    always_comb begin
        stateNext        = state;
        oReady_AM_Output = 1'b0;
        oReady_AS_Label  = 1'b0;
        oValid_BM_Class  = 1'b0;
        joinFire         = 1'b0;
        retireFire       = 1'b0;
        case (state)
            IDLE: begin
                joinFire         = iRST & iValid_AM_Output & iValid_AS_Label;
                oReady_AM_Output = joinFire;
                oReady_AS_Label  = joinFire;
                if (joinFire) begin
                    stateNext = (NC == 1) ? OUT : SCAN;
                end
            end
            SCAN: begin
                if (lastLane) begin
                    stateNext = OUT;
                end
            end
            OUT: begin
                oValid_BM_Class = 1'b1;
                if (iReady_BM_Class) begin
                    retireFire = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Strict signed compare so equal values never displace an earlier (lower) index.
    always_comb begin
        candVal     = laneReg[laneIdx];
        scanBestVal = bestVal;
        scanBestIdx = bestIdx;
        if (candVal > bestVal) begin
            scanBestVal = candVal;
            scanBestIdx = laneIdx;
        end
    end

    // Capture the sample at the join and walk one lane per cycle during the scan.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int k = 0; k < NC; k++) begin
                laneReg[k] <= '0;
            end
            labelReg <= '0;
            bestVal  <= '0;
            bestIdx  <= '0;
            laneIdx  <= '0;
        end else if (joinFire) begin
            for (int k = 0; k < NC; k++) begin
                laneReg[k] <= iData_AM_Output[k*WO +: WO];
            end
            labelReg <= iData_AS_Label;
            bestVal  <= iData_AM_Output[0 +: WO];
            bestIdx  <= '0;
            laneIdx  <= WL'(1);
        end else if (state == SCAN) begin
            bestVal <= scanBestVal;
            bestIdx <= scanBestIdx;
            laneIdx <= laneIdx + WL'(1);
        end
    end

    // Result registers load once, on entry to OUT, and hold through any stall.
    // A label outside 0..NC-1 can never equal an index, so it never scores a hit.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oData_BM_Class <= '0;
            oHit           <= 1'b0;
        end else if (joinFire && (NC == 1)) begin
            oData_BM_Class <= '0;
            oHit           <= (iData_AS_Label == '0);
        end else if ((state == SCAN) && lastLane) begin
            oData_BM_Class <= scanBestIdx;
            oHit           <= (scanBestIdx == labelReg);
        end
    end

`ifdef OUTPUT_ARGMAX_SCORE_EN
    // Winning lane value, loaded alongside the class index.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oData_BM_Score <= '0;
        end else if (joinFire && (NC == 1)) begin
            oData_BM_Score <= iData_AM_Output[0 +: WO];
        end else if ((state == SCAN) && lastLane) begin
            oData_BM_Score <= scanBestVal;
        end
    end
`else
    // Without the score port the winning value lives only in bestVal.
`endif

    // Accuracy counters: clear has priority, each counter saturates on its own.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oCount_Total <= '0;
            oCount_Hit   <= '0;
        end else if (iClear) begin
            oCount_Total <= '0;
            oCount_Hit   <= '0;
        end else if (retireFire) begin
            if (oCount_Total != CNT_MAX) begin
                oCount_Total <= oCount_Total + WCNT'(1);
            end
            if (oHit && (oCount_Hit != CNT_MAX)) begin
                oCount_Hit <= oCount_Hit + WCNT'(1);
            end
        end
    end

endmodule
